// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_port_responder
//  Purpose  : Memory-mapped I/O port for a simple processor data bus. Stores
//             to OUT_DATA are queued in an output FIFO drained by a
//             valid/ready consumer. An 8-bit asynchronous input port is
//             synchronised and monitored for changes. Status and input data
//             are returned combinationally on loads.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   rising-edge clock
//    reset         in   1   asynchronous active-low reset
//    Address       in  32   processor data address
//    WriteData     in  32   processor store data
//    MemWrite      in   1   store strobe
//    MemRead       in   1   load strobe
//    ReadData      out 32   load response (0 unless a readable hit)
//    Hit           out  1   address falls on one of the three registers
//    PortIn        in   8   asynchronous external input pins
//    PortOut       out 32   FIFO head word (0 when empty)
//    PortOutValid  out  1   FIFO non-empty
//    PortOutReady  in   1   consumer accepts the head word
//
//  Register map (offsets from BASE_ADDR)
//    0x0 OUT_DATA  W  push WriteData into the FIFO
//    0x4 STATUS    R  {23'b0, count[4:0], overflow, full, empty, in_changed}
//                     a read clears overflow
//    0x8 IN_DATA   R  {24'b0, in_sync}; a read clears in_changed
// ============================================================================
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        PortOutValid,
  input  logic        PortOutReady
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0]      c_ADDR_OUT  = BASE_ADDR;
  localparam logic [31:0]      c_ADDR_STAT = BASE_ADDR + 32'd4;
  localparam logic [31:0]      c_ADDR_IN   = BASE_ADDR + 32'd8;
  localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;       // in_sync
  logic [7:0]       r_prev;        // in_sync delayed one cycle
  logic             r_in_changed;

  // --------------------------------------------------------------------------
  // Address decode: exact match only, so unaligned addresses never hit
  // --------------------------------------------------------------------------
  logic w_sel_out;
  logic w_sel_stat;
  logic w_sel_in;

  assign w_sel_out  = (Address == c_ADDR_OUT);
  assign w_sel_stat = (Address == c_ADDR_STAT);
  assign w_sel_in   = (Address == c_ADDR_IN);
  assign Hit        = w_sel_out | w_sel_stat | w_sel_in;

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_DEPTH);
  assign w_push_req = MemWrite & w_sel_out;
  // A pop only happens when a word is already visible, so a push into an
  // empty FIFO is never consumed in the same cycle.
  assign w_pop      = ~w_empty & PortOutReady;
  // At full, a simultaneous pop frees the slot the push lands in.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;

  assign PortOutValid = ~w_empty;
  assign PortOut      = w_empty ? 32'd0 : r_mem[r_rd_ptr];

  // Storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WriteData;
    end
  end

  // Depth is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  logic w_stat_rd;
  logic w_in_rd;
  logic w_change;

  assign w_stat_rd = MemRead & w_sel_stat;
  assign w_in_rd   = MemRead & w_sel_in;
  assign w_change  = (r_sync2 != r_prev);

  // A new event in the same cycle as the clearing read is kept, so no
  // overflow or input change is ever lost to a racing read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_in_changed <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_stat_rd) begin
        r_overflow <= 1'b0;
      end
      if (w_change) begin
        r_in_changed <= 1'b1;
      end else if (w_in_rd) begin
        r_in_changed <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Input synchroniser and change-detect history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // --------------------------------------------------------------------------
  // Load response
  // --------------------------------------------------------------------------
  logic [31:0] w_status;

  assign w_status = {23'd0, 5'(r_count), r_overflow, w_full, w_empty, r_in_changed};

  always_comb begin
    ReadData = 32'd0;
    if (w_stat_rd) begin
      ReadData = w_status;
    end else if (w_in_rd) begin
      ReadData = {24'd0, r_sync2};
    end
  end

endmodule
`default_nettype wire
